// File: rtl/pc_gen_pkg.sv
// Shared fetch-PC definitions: state encoding,
// default boot address and target alignment helper.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [31:0] START_ADDR_DEF = 32'h0000_0000;

    // With compressed support only bit 0 must be clear,
    // otherwise targets must be word aligned.
    function automatic logic is_misaligned(
        input logic [1:0] lsb,
        input logic       c_ext
    );
        return c_ext ? lsb[0] : (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_redir_arb.sv
// Fixed-priority redirect picker; channel 0 wins.
// Purely combinational.
module pc_redir_arb #(
    parameter int unsigned N     = 3,
    parameter int unsigned W     = 32,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [N*W-1:0]   pc_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [W-1:0]     tgt_o
);

    // Scan from the lowest priority up so the
    // lowest set index is the last one written.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        tgt_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid_i[k]) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(k);
                tgt_o = pc_i[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator: boot/run/halt FSM, prioritised
// redirects, misalign reporting and fetch counter.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter logic [ADDR_W-1:0] START_ADDR =
        ADDR_W'(START_ADDR_DEF),
    parameter int unsigned N_REDIR = 3,
    parameter int unsigned C_EXT   = 0,
    parameter int unsigned STEP    = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic                      halt_i,
    input  logic [N_REDIR-1:0]        redir_valid_i,
    input  logic [N_REDIR*ADDR_W-1:0] redir_pc_i,
    input  logic                      req_ready_i,
    output logic                      req_valid_o,
    output logic [ADDR_W-1:0]         pc_o,
    output logic                      flush_o,
    output logic                      misalign_o,
    output logic [ADDR_W-1:0]         badaddr_o,
    output logic [CNT_W-1:0]          fetch_cnt_o
);

    localparam logic C_EXT_EN = (C_EXT != 0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                flush_q, flush_d;
    logic                mis_q, mis_d;
    logic [ADDR_W-1:0]   bad_q, bad_d;

    logic                redir_hit;
    logic [ADDR_W-1:0]   redir_tgt;
    logic                tgt_bad;

    pc_redir_arb #(
        .N (N_REDIR),
        .W (ADDR_W)
    ) u_arb (
        .valid_i (redir_valid_i),
        .pc_i    (redir_pc_i),
        .hit_o   (redir_hit),
        .idx_o   (),
        .tgt_o   (redir_tgt)
    );

    assign tgt_bad = is_misaligned(redir_tgt[1:0], C_EXT_EN);

    // Request is offered only while running and not stalled.
    assign req_valid_o = (state_q == ST_RUN) && !stall_i;

    // Next-state: redirect beats halt beats stall beats advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        mis_d   = 1'b0;
        bad_d   = bad_q;
        if (redir_hit) begin
            if (tgt_bad) begin
                mis_d = 1'b1;
                bad_d = redir_tgt;
            end else begin
                pc_d    = redir_tgt;
                flush_d = 1'b1;
                state_d = ST_RUN;
            end
        end else begin
            unique case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    if (halt_i) begin
                        state_d = ST_HALT;
                    end else if (req_valid_o && req_ready_i) begin
                        pc_d  = pc_q + ADDR_W'(STEP);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_BOOT;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
            bad_q   <= bad_d;
        end
    end

    assign pc_o        = pc_q;
    assign flush_o     = flush_q;
    assign misalign_o  = mis_q;
    assign badaddr_o   = bad_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (C_EXT 0 and 1) share
// stimulus; a behavioural model is compared every cycle.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        halt_i = 1'b0;
    logic [2:0]  rv = 3'b000;
    logic [31:0] ch [3];
    logic        ready = 1'b1;
    logic [95:0] rpc;

    logic        dv [2];
    logic [31:0] dpc [2];
    logic        dfl [2];
    logic        dmi [2];
    logic [31:0] dbad [2];
    logic [31:0] dcnt [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign rpc = {ch[2], ch[1], ch[0]};

    pc_gen #(.C_EXT(0)) u0 (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
        .halt_i(halt_i), .redir_valid_i(rv),
        .redir_pc_i(rpc), .req_ready_i(ready),
        .req_valid_o(dv[0]), .pc_o(dpc[0]),
        .flush_o(dfl[0]), .misalign_o(dmi[0]),
        .badaddr_o(dbad[0]), .fetch_cnt_o(dcnt[0])
    );

    pc_gen #(.C_EXT(1)) u1 (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
        .halt_i(halt_i), .redir_valid_i(rv),
        .redir_pc_i(rpc), .req_ready_i(ready),
        .req_valid_o(dv[1]), .pc_o(dpc[1]),
        .flush_o(dfl[1]), .misalign_o(dmi[1]),
        .badaddr_o(dbad[1]), .fetch_cnt_o(dcnt[1])
    );

    // Model: mode 0 booting, 1 running, 2 halted.
    int          m_mode [2];
    logic [31:0] m_pc [2];
    logic [31:0] m_cnt [2];
    logic        m_fl [2];
    logic        m_mi [2];
    logic [31:0] m_bad [2];
    bit          live = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int win;
            int algn;
            algn = (i == 1) ? 2 : 4;
            win = -1;
            for (int k = 2; k >= 0; k--)
                if (rv[k]) win = k;
            if (rst_i) begin
                m_mode[i] = 0; m_pc[i] = 32'h0; m_cnt[i] = 0;
                m_fl[i] = 0; m_mi[i] = 0; m_bad[i] = 0;
            end else begin
                m_fl[i] = 0;
                m_mi[i] = 0;
                if (win >= 0) begin
                    if (ch[win] % algn == 0) begin
                        m_pc[i] = ch[win];
                        m_fl[i] = 1;
                        m_mode[i] = 1;
                    end else begin
                        m_mi[i] = 1;
                        m_bad[i] = ch[win];
                    end
                end else if (m_mode[i] == 0) begin
                    m_mode[i] = 1;
                end else if (m_mode[i] == 1) begin
                    if (halt_i) m_mode[i] = 2;
                    else if (!stall_i && ready) begin
                        m_pc[i] = m_pc[i] + 4;
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
        live = 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 2; i++) begin
                logic ev;
                ev = (m_mode[i] == 1) && !stall_i;
                chk($sformatf("m%0d.req_valid", i), 32'(dv[i]), 32'(ev));
                chk($sformatf("m%0d.pc", i), dpc[i], m_pc[i]);
                chk($sformatf("m%0d.flush", i), 32'(dfl[i]), 32'(m_fl[i]));
                chk($sformatf("m%0d.misalign", i), 32'(dmi[i]), 32'(m_mi[i]));
                chk($sformatf("m%0d.badaddr", i), dbad[i], m_bad[i]);
                chk($sformatf("m%0d.cnt", i), dcnt[i], m_cnt[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [2:0] v, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [31:0] a2);
        rv = v; ch[0] = a0; ch[1] = a1; ch[2] = a2;
    endtask

    logic [31:0] hold_pc;

    initial begin
        redir(3'b000, 0, 0, 0);
        tick(); tick();
        chk("rst.pc", dpc[0], 32'h0);
        chk("rst.cnt", dcnt[0], 32'h0);
        rst_i = 1'b0;
        #1 chk("boot.valid", 32'(dv[0]), 32'h0);
        tick();
        chk("run.valid", 32'(dv[0]), 32'h1);
        chk("run.pc0", dpc[0], 32'h0);
        tick(); chk("adv.pc4", dpc[0], 32'h4);
        chk("adv.cnt1", dcnt[0], 32'h1);
        tick(); chk("adv.pc8", dpc[0], 32'h8);
        tick(); chk("adv.pcC", dpc[0], 32'hC);
        chk("adv.cnt3", dcnt[0], 32'h3);
        tick(); chk("adv.pc10", dpc[0], 32'h10);
        ready = 1'b0;
        repeat (3) tick();
        chk("noready.pc", dpc[0], 32'h10);
        stall_i = 1'b1; ready = 1'b1;
        tick();
        chk("stall.pc", dpc[0], 32'h10);
        chk("stall.valid", 32'(dv[0]), 32'h0);
        stall_i = 1'b0;
        tick(); chk("unstall.pc", dpc[0], 32'h14);
        // priority under stall
        stall_i = 1'b1;
        redir(3'b110, 0, 32'h200, 32'h300);
        tick();
        chk("prio.pc", dpc[0], 32'h200);
        chk("prio.flush", 32'(dfl[0]), 32'h1);
        redir(3'b111, 32'h100, 32'h200, 32'h300);
        tick();
        chk("prio0.pc", dpc[0], 32'h100);
        chk("prio0.flush", 32'(dfl[0]), 32'h1);
        redir(3'b000, 0, 0, 0);
        stall_i = 1'b0;
        tick(); chk("flush.end", 32'(dfl[0]), 32'h0);
        // misalign
        hold_pc = dpc[0];
        redir(3'b010, 0, 32'h202, 0);
        tick();
        chk("mis.pc", dpc[0], hold_pc);
        chk("mis.flag", 32'(dmi[0]), 32'h1);
        chk("mis.bad", dbad[0], 32'h202);
        chk("mis.flush", 32'(dfl[0]), 32'h0);
        chk("cext.pc", dpc[1], 32'h202);
        redir(3'b000, 0, 0, 0);
        tick(); chk("mis.end", 32'(dmi[0]), 32'h0);
        chk("mis.badhold", dbad[0], 32'h202);
        // halt and wake
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        hold_pc = dpc[0];
        repeat (10) tick();
        chk("halt.pc", dpc[0], hold_pc);
        chk("halt.valid", 32'(dv[0]), 32'h0);
        redir(3'b001, 32'h80, 0, 0);
        tick();
        chk("wake.pc", dpc[0], 32'h80);
        chk("wake.flush", 32'(dfl[0]), 32'h1);
        chk("wake.valid", 32'(dv[0]), 32'h1);
        halt_i = 1'b1;
        redir(3'b001, 32'h40, 0, 0);
        tick();
        chk("halt+redir.pc", dpc[0], 32'h40);
        halt_i = 1'b0;
        redir(3'b000, 0, 0, 0);
        tick(); chk("nohalt.pc", dpc[0], 32'h44);
        // wrap
        redir(3'b001, 32'hFFFF_FFFC, 0, 0);
        tick();
        redir(3'b000, 0, 0, 0);
        chk("wrap.top", dpc[0], 32'hFFFF_FFFC);
        tick(); chk("wrap.pc", dpc[0], 32'h0);
        // reset during halt and during a redirect
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        rst_i = 1'b1;
        tick();
        chk("rsthalt.pc", dpc[0], 32'h0);
        chk("rsthalt.cnt", dcnt[0], 32'h0);
        rst_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b1;
        redir(3'b001, 32'h500, 0, 0);
        tick();
        chk("rstredir.pc", dpc[0], 32'h0);
        chk("rstredir.flush", 32'(dfl[0]), 32'h0);
        chk("rstredir.cnt", dcnt[0], 32'h0);
        rst_i = 1'b0;
        redir(3'b000, 0, 0, 0);
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised next-PC generator for the fetch stage and successor to the single-redirect PC register. Holds the architectural fetch PC and issues fetch requests over a valid/ready handshake. Arbitrates N prioritised redirect sources (e.g. trap, branch, jump). Adds halt/wake, misaligned-target detection and an accepted-fetch counter.

Parameters:
ADDR_W, 32, PC width in bits.
START_ADDR, 32'h0000_0000, PC value loaded on reset.
N_REDIR, 3, number of redirect channels; index 0 has highest priority.
C_EXT, 0, 1 = 2-byte target alignment permitted; 0 = 4-byte alignment required.
STEP, 4, sequential increment on each accepted fetch.
CNT_W, 32, width of the fetch counter.

Ports:
clk_i  in  1  clock; all state changes on the rising edge.
rst_i  in  1  synchronous reset, active-high.
stall_i  in  1  hold PC and suppress requests; does not block redirects.
halt_i  in  1  enter HALT (WFI-style).
redir_valid_i  in  N_REDIR  per-channel redirect request.
redir_pc_i  in  N_REDIR*ADDR_W  targets, packed; channel k occupies bits [k*ADDR_W +: ADDR_W].
req_ready_i  in  1  fetch unit accepts the request.
req_valid_o  out  1  fetch request valid.
pc_o  out  ADDR_W  current fetch PC (registered).
flush_o  out  1  one-cycle pulse after an accepted redirect; fetch unit discards in-flight data.
misalign_o  out  1  one-cycle pulse: the winning redirect target was misaligned.
badaddr_o  out  ADDR_W  offending target; valid while misalign_o is high, holds last value otherwise.
fetch_cnt_o  out  CNT_W  count of accepted fetches.

Behaviour:
- Reset (rst_i=1, overrides everything):
  - pc_o=START_ADDR, state=BOOT.
  - flush_o=0, misalign_o=0, badaddr_o=0, fetch_cnt_o=0.
- req_valid_o = (state==RUN) && !stall_i. Combinational from state and stall_i only; no dependency on req_ready_i.
- States:
  - BOOT: lasts exactly one cycle after reset deasserts, then goes to RUN. req_valid_o=0.
  - RUN: normal fetching.
  - HALT: req_valid_o=0, pc_o held.
- Per-cycle priority, highest first: reset > redirect > halt > stall > handshake advance.
- Redirect:
  - The winner is the lowest index k with redir_valid_i[k]=1. Lower-priority channels are ignored that cycle.
  - The winner is accepted in any state (BOOT/RUN/HALT) and regardless of stall_i or req_ready_i.
- Aligned target (C_EXT=0: target[1:0]==0; C_EXT=1: target[0]==0):
  - pc_o <= target next cycle; flush_o=1 next cycle.
  - State becomes RUN, including from HALT (wake) and from BOOT.
  - An in-flight request in the same cycle is not counted, even if req_ready_i=1.
- Misaligned target:
  - pc_o held; state unchanged.
  - misalign_o=1 and badaddr_o=target next cycle; flush_o=0.
  - The trap redirect that follows is expected on channel 0.
- halt_i in RUN with no redirect: go to HALT next cycle, pc_o held. In HALT only a redirect exits. halt_i while already in HALT has no effect.
- Advance: in RUN with req_valid_o && req_ready_i and no redirect/halt:
  - pc_o <= pc_o + STEP.
  - fetch_cnt_o <= fetch_cnt_o + 1.
- Otherwise pc_o is held. req_ready_i without req_valid_o has no effect.
- Arithmetic: pc_o + STEP wraps modulo 2^ADDR_W with no flag. fetch_cnt_o wraps modulo 2^CNT_W.
- The request may be retracted only via a redirect (flush_o follows). Otherwise pc_o is stable while req_valid_o is high and req_ready_i is low.
- flush_o and misalign_o are exactly one cycle wide. Back-to-back redirects produce back-to-back pulses.
- A redirect in the cycle rst_i is high is discarded.

Decomposition:
- Shared package (core defines header): state encoding (BOOT/RUN/HALT), START_ADDR default, alignment-mask helper per C_EXT.
- One natural sub-module: pc_redir_arb. Purely combinational fixed-priority picker; inputs are the valid vector and packed targets, outputs are hit, winning index and target.
- FSM, PC register and counter stay in pc_gen.

Test Plan:
- Reset/boot, ready tied 1:
  - Release rst_i.
  - Cycle 1: req_valid_o=0, pc_o=0x0.
  - Cycle 2: req_valid_o=1, pc_o=0x0.
  - Following cycles: pc_o=0x4, 0x8, 0xC; fetch_cnt_o=1, 2, 3.
- Handshake/stall:
  - At pc_o=0x10, ready=0 for 3 cycles: pc_o stays 0x10.
  - stall_i=1 with ready=1: req_valid_o=0, pc_o=0x10.
  - Release stall: pc_o=0x14 next cycle.
- Priority:
  - redir_valid_i=3'b110 with ch1=0x200, ch2=0x300, plus stall_i=1: pc_o=0x200 next cycle, flush_o pulse.
  - Same cycle ch0=0x100 valid: pc_o=0x100.
- Misalign:
  - C_EXT=0, redirect ch1 to 0x202: pc_o unchanged, misalign_o=1, badaddr_o=0x202, flush_o=0.
  - Repeat with C_EXT=1: pc_o=0x202.
- Halt/wake:
  - halt_i in RUN: req_valid_o=0, pc_o held for 10 cycles.
  - ch0 redirect to 0x80: RUN, pc_o=0x80, flush_o pulse.
  - halt_i together with a redirect: redirect taken, no HALT.
- Wrap and mid-op reset:
  - Redirect to 0xFFFF_FFFC, accept one fetch: pc_o=0x0.
  - Assert rst_i during HALT and during a redirect: pc_o=START_ADDR, fetch_cnt_o=0, flush_o=0.
